uart_arb: RTL and testbench
===========================

// Module: uart_arb
// PURPOSE
// - UART command endpoint: 8N1 receiver, command-line parser and 8N1 transmitter with a TX arbiter.
// - Sits between the board UART pins and two status LEDs.
// - Receives two-character commands terminated by CR (0x0D), drives led_1/led_2 and transmits a 4-byte reply.
// PARAMETERS
// - CLKS_PER_BIT  default 868  clk cycles per UART bit (100 MHz / 115200); legal range >= 8.
// PORTS
// - clk          in   1  system clock; all logic on rising edge.
// - rst_n        in   1  asynchronous, active-low reset.
// - data_in_RX   in   1  UART serial input, idle high, asynchronous to clk.
// - data_out_TX  out  1  UART serial output, idle high.
// - led_1        out  1  high after a valid "OK" command.
// - led_2        out  1  high after a valid "KO" command.
// BEHAVIOUR
// - Reset values: data_out_TX=1, led_1=0, led_2=0, RX/TX FSMs IDLE, command buffer empty, reply idle.
// - Reset mid-frame aborts both RX and TX immediately; TX line returns high asynchronously.
// - RX input: 2-flop synchroniser before any use.
// - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: a low synchronised sample -> START.
//   - START: wait CLKS_PER_BIT/2 cycles; if still low -> DATA, else glitch -> IDLE.
//   - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits.
//   - STOP: sample after CLKS_PER_BIT; high -> 1-cycle rx_valid with byte, low -> framing error, byte dropped.
//   - Either way -> IDLE; the next start bit is accepted immediately.
// - Parser: 2-byte shift buffer {prev,last}, shifted on each rx_valid byte other than CR/LF.
//   - LF (0x0A) is ignored.
//   - CR with buffer=="OK" (0x4F,0x4B): led_1<=1, led_2<=0, reply "OK\r\n".
//   - CR with buffer=="KO" (0x4B,0x4F): led_2<=1, led_1<=0, reply "KO\r\n".
//   - CR with any other buffer (incl. empty or 1 char): LEDs unchanged, reply "ER\r\n".
//   - Buffer cleared after every CR; only the last two chars before CR count ("XOK"+CR == "OK").
//   - LEDs update the cycle after the CR rx_valid.
//   - CR while a reply is still being sent: LEDs still update, new reply dropped (no queue).
// - TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE, each bit exactly CLKS_PER_BIT cycles.
//   - tx_busy high from load until end of stop bit.
// - Arbiter: grants the TX FSM one byte at a time when TX is idle.
//   - Reply sequencer sends its 4 bytes back-to-back; the next start bit follows the stop bit with <=2 idle cycles.
//   - First reply start bit begins <=3 cycles after the CR rx_valid.
// CONFIGURATION
// - UART_ECHO_EN defined: every valid received byte (incl. CR/LF) is loaded into a 1-byte echo register.
//   - Arbiter priority: echo before reply at each byte boundary, so the CR echo precedes "OK\r\n".
//   - Echo register already full: the new echo byte is dropped.
// - UART_ECHO_EN undefined: no echo logic; TX carries replies only.
// TESTING
// - Use CLKS_PER_BIT=87 and a 10 ns clk; drive 8N1 frames with 2 stop-bit gaps.
// - Reset: hold rst_n low 10 cycles -> data_out_TX=1, led_1=0, led_2=0; idle 400 cycles -> TX stays high.
// - Send 'O','K',0x0D -> led_1=1, led_2=0; TX decodes 0x4F,0x4B,0x0D,0x0A.
// - Then send 'K','O',0x0D -> led_1=0, led_2=1; TX decodes 0x4B,0x4F,0x0D,0x0A.
// - Send 'A',0x0D -> LEDs unchanged; TX decodes 0x45,0x52,0x0D,0x0A.
// - Framing: a frame with a low stop bit is dropped; a 20-cycle low glitch never yields a byte.
// - Send 'O','K',0x0D, then a second "OK"+CR during the reply -> exactly one 4-byte reply; led_1=1.
// - With UART_ECHO_EN: send 'O' -> TX echoes 0x4F within CLKS_PER_BIT+3 cycles of rx_valid.

Source files
------------

// File: rtl/uart_arb.sv
// UART command endpoint: 8N1 RX, "OK"/"KO" line parser, 8N1 TX with reply/echo arbiter.
// Optional byte echo is enabled with `define UART_ECHO_EN.
`timescale 1ns/1ps
module uart_arb #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst_n,
   input  logic data_in_RX,
   output logic data_out_TX,
   output logic led_1,
   output logic led_2
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_O  = 8'h4F;
   localparam logic [7:0] CH_K  = 8'h4B;
   localparam logic [7:0] CH_E  = 8'h45;
   localparam logic [7:0] CH_R  = 8'h52;

   logic [1:0]    r_sync;
   logic          w_rx;
   logic [1:0]    r_rx_st;
   logic [CW-1:0] r_rx_cnt;
   logic [2:0]    r_rx_idx;
   logic [7:0]    r_rx_byte;
   logic          r_rx_valid;

   logic [7:0] r_prev, r_last;
   logic [7:0] r_rep_c0, r_rep_c1;
   logic       r_rep_act;
   logic [2:0] r_rep_idx;
   logic       r_led1, r_led2;
   logic       w_is_ok, w_is_ko;
   logic [7:0] w_rep_byte;

   logic [1:0]    r_tx_st;
   logic [CW-1:0] r_tx_cnt;
   logic [2:0]    r_tx_idx;
   logic [7:0]    r_tx_shr;
   logic          r_tx_out;
   logic          w_tx_idle;
   logic          w_grant_echo, w_grant_rep, w_tx_load;
   logic [7:0]    w_echo_byte, w_tx_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= 2'b11;
      else        r_sync <= {r_sync[0], data_in_RX};
   end
   assign w_rx = r_sync[1];

   // START re-checks the line at mid-bit so a short glitch falls back to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_st    <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_byte  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         unique case (r_rx_st)
            S_IDLE: begin
               if (!w_rx) begin
                  r_rx_st  <= S_START;
                  r_rx_cnt <= '0;
               end
            end
            S_START: begin
               if (r_rx_cnt == HALF_END) begin
                  r_rx_cnt <= '0;
                  r_rx_idx <= '0;
                  r_rx_st  <= w_rx ? S_IDLE : S_DATA;
               end else r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            S_DATA: begin
               if (r_rx_cnt == BIT_END) begin
                  r_rx_cnt  <= '0;
                  r_rx_byte <= {w_rx, r_rx_byte[7:1]};
                  r_rx_idx  <= r_rx_idx + 1'b1;
                  if (r_rx_idx == 3'd7) r_rx_st <= S_STOP;
               end else r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            default: begin
               if (r_rx_cnt == BIT_END) begin
                  r_rx_valid <= w_rx;
                  r_rx_st    <= S_IDLE;
               end else r_rx_cnt <= r_rx_cnt + 1'b1;
            end
         endcase
      end
   end

   assign w_is_ok = (r_prev == CH_O) && (r_last == CH_K);
   assign w_is_ko = (r_prev == CH_K) && (r_last == CH_O);

   // Reply stays active until its LF has left the wire, so a CR mid-reply is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev    <= '0;
         r_last    <= '0;
         r_rep_c0  <= '0;
         r_rep_c1  <= '0;
         r_rep_act <= 1'b0;
         r_rep_idx <= '0;
         r_led1    <= 1'b0;
         r_led2    <= 1'b0;
      end else begin
         if (w_grant_rep) r_rep_idx <= r_rep_idx + 1'b1;
         else if (r_rep_act && r_rep_idx[2] && w_tx_idle) r_rep_act <= 1'b0;
         if (r_rx_valid) begin
            if (r_rx_byte == CH_CR) begin
               r_prev <= '0;
               r_last <= '0;
               if (w_is_ok) begin
                  r_led1 <= 1'b1;
                  r_led2 <= 1'b0;
               end else if (w_is_ko) begin
                  r_led1 <= 1'b0;
                  r_led2 <= 1'b1;
               end
               if (!r_rep_act) begin
                  r_rep_act <= 1'b1;
                  r_rep_idx <= '0;
                  r_rep_c0  <= w_is_ok ? CH_O : (w_is_ko ? CH_K : CH_E);
                  r_rep_c1  <= w_is_ok ? CH_K : (w_is_ko ? CH_O : CH_R);
               end
            end else if (r_rx_byte != CH_LF) begin
               r_prev <= r_last;
               r_last <= r_rx_byte;
            end
         end
      end
   end

   always_comb begin
      w_rep_byte = CH_LF;
      unique case (r_rep_idx[1:0])
         2'd0:    w_rep_byte = r_rep_c0;
         2'd1:    w_rep_byte = r_rep_c1;
         2'd2:    w_rep_byte = CH_CR;
         default: w_rep_byte = CH_LF;
      endcase
   end

`ifdef UART_ECHO_EN
   logic [7:0] r_echo;
   logic       r_echo_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_echo      <= '0;
         r_echo_full <= 1'b0;
      end else if (r_rx_valid && (!r_echo_full || w_grant_echo)) begin
         r_echo      <= r_rx_byte;
         r_echo_full <= 1'b1;
      end else if (w_grant_echo) begin
         r_echo_full <= 1'b0;
      end
   end
   assign w_grant_echo = r_echo_full & w_tx_idle;
   assign w_echo_byte  = r_echo;
`else
   assign w_grant_echo = 1'b0;
   assign w_echo_byte  = 8'h00;
`endif

   assign w_tx_idle   = (r_tx_st == S_IDLE);
   assign w_grant_rep = r_rep_act & ~r_rep_idx[2] & w_tx_idle & ~w_grant_echo;
   assign w_tx_load   = w_grant_echo | w_grant_rep;
   assign w_tx_data   = w_grant_echo ? w_echo_byte : w_rep_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_st  <= S_IDLE;
         r_tx_cnt <= '0;
         r_tx_idx <= '0;
         r_tx_shr <= '0;
         r_tx_out <= 1'b1;
      end else begin
         unique case (r_tx_st)
            S_IDLE: begin
               r_tx_out <= 1'b1;
               if (w_tx_load) begin
                  r_tx_shr <= w_tx_data;
                  r_tx_cnt <= '0;
                  r_tx_out <= 1'b0;
                  r_tx_st  <= S_START;
               end
            end
            S_START: begin
               if (r_tx_cnt == BIT_END) begin
                  r_tx_cnt <= '0;
                  r_tx_idx <= '0;
                  r_tx_out <= r_tx_shr[0];
                  r_tx_shr <= {1'b0, r_tx_shr[7:1]};
                  r_tx_st  <= S_DATA;
               end else r_tx_cnt <= r_tx_cnt + 1'b1;
            end
            S_DATA: begin
               if (r_tx_cnt == BIT_END) begin
                  r_tx_cnt <= '0;
                  if (r_tx_idx == 3'd7) begin
                     r_tx_out <= 1'b1;
                     r_tx_st  <= S_STOP;
                  end else begin
                     r_tx_idx <= r_tx_idx + 1'b1;
                     r_tx_out <= r_tx_shr[0];
                     r_tx_shr <= {1'b0, r_tx_shr[7:1]};
                  end
               end else r_tx_cnt <= r_tx_cnt + 1'b1;
            end
            default: begin
               if (r_tx_cnt == BIT_END) r_tx_st <= S_IDLE;
               else r_tx_cnt <= r_tx_cnt + 1'b1;
            end
         endcase
      end
   end

   assign data_out_TX = r_tx_out;
   assign led_1       = r_led1;
   assign led_2       = r_led2;
endmodule

// File: tb/tb_uart_arb.sv
// Bench for uart_arb: table of command lines plus framing, glitch,
// overlap and (with UART_ECHO_EN) echo sequences, decoded from the TX pin.
`timescale 1ns/1ps
module tb_uart_arb;
   localparam int CPB = 87;

   typedef struct {
      int          n;
      logic [31:0] b;
      logic        l1;
      logic        l2;
      logic [7:0]  r0;
      logic [7:0]  r1;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic data_in_RX;
   logic data_out_TX;
   logic led_1, led_2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t_stop = 0;
   logic [7:0] rx_q[$];
   int         t_q[$];

   uart_arb #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .data_in_RX(data_in_RX),
      .data_out_TX(data_out_TX),
      .led_1(led_1),
      .led_2(led_2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   // TX line decoder: start time logged at the validated start bit
   initial begin
      logic [7:0] b;
      int ts;
      forever begin
         @(negedge data_out_TX);
         if (rst_n !== 1'b1) continue;
         ts = cyc;
         repeat (CPB/2) @(negedge clk);
         if (data_out_TX !== 1'b0) continue;
         t_q.push_back(ts);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = data_out_TX;
         end
         repeat (CPB) @(negedge clk);
         chk("tx stop bit", {31'd0, data_out_TX}, 32'd1);
         rx_q.push_back(b);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input int n);
      data_in_RX = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
      t_stop = cyc;
      if (bad_stop) begin
         drive(1'b0, CPB/2 + 10);
         drive(1'b1, CPB - (CPB/2 + 10));
      end else drive(1'b1, CPB);
      drive(1'b1, 2*CPB);
   endtask

   task automatic finish_cmd(input string nm, input logic [7:0] exp[$],
                             input logic el1, input logic el2, input bit lat);
      int waited = 0;
      int base, d;
      while (rx_q.size() < exp.size() && waited < 8000) begin
         @(negedge clk);
         waited++;
      end
      chk({nm, " timeout"}, {31'd0, waited < 8000}, 32'd1);
      repeat (2*CPB) @(negedge clk);
      chk({nm, " nbytes"}, t_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
         chk({nm, " byte"}, {24'd0, rx_q[i]}, {24'd0, exp[i]});
      chk({nm, " led_1"}, {31'd0, led_1}, {31'd0, el1});
      chk({nm, " led_2"}, {31'd0, led_2}, {31'd0, el2});
      if (exp.size() >= 4 && t_q.size() == exp.size()) begin
         base = t_q.size() - 4;
         for (int k = 1; k < 4; k++) begin
            d = t_q[base+k] - t_q[base+k-1];
            chk({nm, " gap"}, {31'd0, d >= 10*CPB && d <= 10*CPB + 3}, 32'd1);
         end
         if (lat) begin
            d = t_q[base] - t_stop;
            chk({nm, " latency"}, {31'd0, d >= 0 && d <= CPB/2 + 10}, 32'd1);
         end
      end
   endtask

   initial begin
      vec_t vecs[6];
      logic [7:0] exp[$];
      logic [31:0] w;
      bit hi_ok;
      bit lat;
      int nlf;

      vecs[0] = '{3, 32'h000D4B4F, 1'b1, 1'b0, 8'h4F, 8'h4B};
      vecs[1] = '{3, 32'h000D4F4B, 1'b0, 1'b1, 8'h4B, 8'h4F};
      vecs[2] = '{2, 32'h00000D41, 1'b0, 1'b1, 8'h45, 8'h52};
      vecs[3] = '{4, 32'h0D4B4F58, 1'b1, 1'b0, 8'h4F, 8'h4B};
      vecs[4] = '{4, 32'h0D4F0A4B, 1'b0, 1'b1, 8'h4B, 8'h4F};
      vecs[5] = '{4, 32'h0D4B4B4F, 1'b0, 1'b1, 8'h45, 8'h52};
`ifdef UART_ECHO_EN
      lat = 1'b0;
`else
      lat = 1'b1;
`endif

      rst_n = 1'b0;
      data_in_RX = 1'b1;
      repeat (10) @(negedge clk);
      chk("reset tx", {31'd0, data_out_TX}, 32'd1);
      chk("reset led_1", {31'd0, led_1}, 32'd0);
      chk("reset led_2", {31'd0, led_2}, 32'd0);
      rst_n = 1'b1;
      hi_ok = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (data_out_TX !== 1'b1) hi_ok = 1'b0;
      end
      chk("idle tx high", {31'd0, hi_ok}, 32'd1);
      chk("idle no bytes", rx_q.size(), 0);

      for (int v = 0; v < 6; v++) begin
         rx_q.delete();
         t_q.delete();
         exp.delete();
         w = vecs[v].b;
         for (int i = 0; i < vecs[v].n; i++) begin
            send_byte(w[8*i +: 8], 1'b0);
`ifdef UART_ECHO_EN
            exp.push_back(w[8*i +: 8]);
`endif
         end
         exp.push_back(vecs[v].r0);
         exp.push_back(vecs[v].r1);
         exp.push_back(8'h0D);
         exp.push_back(8'h0A);
         finish_cmd($sformatf("vec%0d", v), exp, vecs[v].l1, vecs[v].l2, lat);
      end

      // bad stop bit: 'O' is dropped, so "K"+CR answers ER
      rx_q.delete();
      t_q.delete();
      exp.delete();
      send_byte(8'h4F, 1'b1);
      send_byte(8'h4B, 1'b0);
      send_byte(8'h0D, 1'b0);
`ifdef UART_ECHO_EN
      exp.push_back(8'h4B);
      exp.push_back(8'h0D);
`endif
      exp.push_back(8'h45);
      exp.push_back(8'h52);
      exp.push_back(8'h0D);
      exp.push_back(8'h0A);
      finish_cmd("framing", exp, 1'b0, 1'b1, lat);

      // a 20-cycle glitch between 'O' and 'K' must not insert a byte
      rx_q.delete();
      t_q.delete();
      exp.delete();
      send_byte(8'h4F, 1'b0);
      drive(1'b0, 20);
      drive(1'b1, 3*CPB);
      send_byte(8'h4B, 1'b0);
      send_byte(8'h0D, 1'b0);
`ifdef UART_ECHO_EN
      exp.push_back(8'h4F);
      exp.push_back(8'h4B);
      exp.push_back(8'h0D);
`endif
      exp.push_back(8'h4F);
      exp.push_back(8'h4B);
      exp.push_back(8'h0D);
      exp.push_back(8'h0A);
      finish_cmd("glitch", exp, 1'b1, 1'b0, lat);

      // second command arrives while the first reply is on the wire
      rx_q.delete();
      t_q.delete();
      exp.delete();
      send_byte(8'h4B, 1'b0);
      send_byte(8'h0D, 1'b0);
      repeat (6000) @(negedge clk);
      rx_q.delete();
      t_q.delete();
      send_byte(8'h4F, 1'b0);
      send_byte(8'h4B, 1'b0);
      send_byte(8'h0D, 1'b0);
      send_byte(8'h4F, 1'b0);
      send_byte(8'h4B, 1'b0);
      send_byte(8'h0D, 1'b0);
`ifdef UART_ECHO_EN
      repeat (80*CPB) @(negedge clk);
      nlf = 0;
      foreach (rx_q[i]) if (rx_q[i] == 8'h0A) nlf++;
      chk("overlap lf count", nlf, 1);
      chk("overlap led_1", {31'd0, led_1}, 32'd1);
      chk("overlap led_2", {31'd0, led_2}, 32'd0);
`else
      exp.push_back(8'h4F);
      exp.push_back(8'h4B);
      exp.push_back(8'h0D);
      exp.push_back(8'h0A);
      finish_cmd("overlap", exp, 1'b1, 1'b0, 1'b0);
      nlf = 0;
      foreach (rx_q[i]) if (rx_q[i] == 8'h0A) nlf++;
      chk("overlap lf count", nlf, 1);
`endif

`ifdef UART_ECHO_EN
      rx_q.delete();
      t_q.delete();
      send_byte(8'h4F, 1'b0);
      repeat (12*CPB) @(negedge clk);
      chk("echo nbytes", t_q.size(), 1);
      if (rx_q.size() > 0) begin
         chk("echo byte", {24'd0, rx_q[0]}, 32'h4F);
         chk("echo latency",
             {31'd0, (t_q[0] - t_stop) >= 0 && (t_q[0] - t_stop) <= CPB + CPB/2 + 3}, 32'd1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
